// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//
// Shared definitions for the four-digit multiplexed seven-segment display.
//   - scan_state_e : scan FSM states (BLANK = anodes forced off, DRIVE = digit lit)
//   - SEG_0..SEG_F : active-low segment codes, bit 6 = g ... bit 0 = a
//   - ANODE_OFF    : all four active-low anodes released
//   - SEG_OFF      : all seven active-low segments dark
//   - DISPLAY_OFF  : {ANODE_OFF, SEG_OFF}, the fully dark display word
// -----------------------------------------------------------------------------
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Segment order is {g, f, e, d, c, b, a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;  // lower-case b
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;  // lower-case d
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [3:0]  ANODE_OFF   = 4'b1111;
  localparam logic [6:0]  SEG_OFF     = 7'h7F;
  localparam logic [10:0] DISPLAY_OFF = {ANODE_OFF, SEG_OFF};

endpackage

// File: rtl/hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
//
// Purely combinational hex-digit to seven-segment decoder covering 0-9 and
// A, b, C, d, E, F.
//
// Ports
//   hex : 4-bit hex digit to display
//   seg : active-low segment pattern, bit 6 = g ... bit 0 = a
// -----------------------------------------------------------------------------
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for a four-digit common-anode display.
// Each digit owns a slot of SCAN_DIV cycles; the first BLANK_CYC cycles of a
// slot keep every anode off to stop the previous digit ghosting into the next.
// The displayed value lives in a shadow register that only updates on the last
// DRIVE cycle of digit 3, so a frame is never drawn with mixed old/new data.
//
// Parameters
//   SCAN_DIV  : clock cycles per digit slot
//   BLANK_CYC : anode-off cycles at the start of every slot (1..SCAN_DIV-1)
//
// Ports
//   CLK         : clock, all state on the rising edge
//   RST         : synchronous active-high reset
//   data_in     : four hex digits, digit i = data_in[4i+3:4i], digit 0 rightmost
//   blank_in    : per-digit blank mask, bit i = 1 keeps digit i dark
//   load        : update request, held with data_in/blank_in until ack
//   ack         : one-cycle pulse after data_in/blank_in were captured
//   display_out : registered {anodes[3:0], segments[6:0]}, all active-low
// -----------------------------------------------------------------------------
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] data_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
  output logic        ack,
  output logic [10:0] display_out
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  // Scan position
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  scan_state_e      state_q, state_d;

  // Shadow copy of the displayed value
  logic [15:0] data_q;
  logic [3:0]  blank_q;

  logic        ack_q;
  logic [10:0] out_q, out_d;

  logic        slot_end;
  logic        frame_end;
  logic        capture;
  logic [3:0]  cur_hex;
  logic [6:0]  cur_seg;
  logic [3:0]  anode_on;

  assign slot_end  = (cnt_q == CNT_LAST);
  // BLANK_CYC < SCAN_DIV guarantees the last slot cycle is a DRIVE cycle.
  assign frame_end = slot_end && (dig_q == 2'd3);
  assign capture   = frame_end && load;

  // ---------------------------------------------------------------------------
  // Next-state: slot counter, digit index and BLANK/DRIVE phase
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    dig_d   = dig_q;
    state_d = state_q;

    if (slot_end) begin
      cnt_d = '0;
      dig_d = dig_q + 2'd1;
    end

    unique case (state_q)
      // Enter DRIVE on the edge where the counter reaches BLANK_CYC.
      BLANK: if (!slot_end && (cnt_d == CNT_BLANK)) state_d = DRIVE;
      DRIVE: if (slot_end) state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output word for the current position, registered below
  // ---------------------------------------------------------------------------
  assign cur_hex  = data_q[{dig_q, 2'b00} +: 4];
  assign anode_on = ANODE_OFF & ~(4'b0001 << dig_q);

  hex_to_7seg u_hex_to_7seg (
    .hex (cur_hex),
    .seg (cur_seg)
  );

  always_comb begin
    out_d = DISPLAY_OFF;
    if ((state_q == DRIVE) && !blank_q[dig_q]) begin
      out_d = {anode_on, cur_seg};
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      dig_q   <= 2'd0;
      state_q <= BLANK;
      data_q  <= 16'h0000;
      blank_q <= 4'b0000;
      ack_q   <= 1'b0;
      out_q   <= DISPLAY_OFF;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      state_q <= state_d;
      ack_q   <= capture;
      out_q   <= out_d;
      if (capture) begin
        data_q  <= data_in;
        blank_q <= blank_in;
      end
    end
  end

  assign ack         = ack_q;
  assign display_out = out_q;

endmodule
